// File: rtl/tl_ul_arbiter_pkg.sv
// Shared TileLink-UL definitions: A/D opcode constants and a clog2 helper
// used to size tag, index and counter fields.
package tl_ul_arbiter_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA = 3'd0,
    A_GET           = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tl_ul_arbiter_rr_arbiter.sv
// Round-robin grant logic: the search starts at the pointer and wraps at
// WIDTH, so non-power-of-two widths never favour a low index.
module rr_arbiter
  import tl_ul_arbiter_pkg::*;
#(
  parameter  int WIDTH = 2,
  localparam int IW    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  logic [IW-1:0] ptr_r;
  logic [IW:0]   sum_s;
  logic [IW:0]   cand_s;
  logic          hit_s;

  // Circular first-requester search starting at ptr_r
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int off = 0; off < WIDTH; off++) begin
      sum_s     = {1'b0, ptr_r} + (IW+1)'(off);
      cand_s    = (sum_s >= (IW+1)'(WIDTH)) ? (sum_s - (IW+1)'(WIDTH)) : sum_s;
      hit_s     = !any && req[cand_s[IW-1:0]];
      grant     = grant | (hit_s ? (WIDTH'(1) << cand_s[IW-1:0]) : '0);
      grant_idx = hit_s ? cand_s[IW-1:0] : grant_idx;
      any       = any | hit_s;
    end
  end

  // Pointer moves one past the winner only when the grant is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (advance && any) begin
      ptr_r <= (grant_idx == IW'(WIDTH - 1)) ? {IW{1'b0}} : (grant_idx + IW'(1));
    end
  end

endmodule

// File: rtl/tl_ul_arbiter.sv
// TileLink-UL N:1 arbiter with registered A path, source tagging and D routing.
// Optional macro TL_ARB_PERF_EN adds saturating per-master grant counters.
module tl_ul_arbiter
  import tl_ul_arbiter_pkg::*;
#(
  parameter  int MASTERS    = 2,
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 512,
  parameter  int SRC_WIDTH  = 4,
  parameter  int MAX_OUTST  = 4,
  localparam int IDX_W      = clog2(MASTERS),
  localparam int TAG_W      = SRC_WIDTH + IDX_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [MASTERS-1:0]                  m_a_valid,
  output logic [MASTERS-1:0]                  m_a_ready,
  input  logic [MASTERS-1:0][2:0]             m_a_opcode,
  input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]  m_a_address,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]  m_a_data,
  input  logic [MASTERS-1:0][SRC_WIDTH-1:0]   m_a_source,
  output logic                                s_a_valid,
  input  logic                                s_a_ready,
  output logic [2:0]                          s_a_opcode,
  output logic [ADDR_WIDTH-1:0]               s_a_address,
  output logic [DATA_WIDTH-1:0]               s_a_data,
  output logic [TAG_W-1:0]                    s_a_source,
  input  logic                                s_d_valid,
  output logic                                s_d_ready,
  input  logic [2:0]                          s_d_opcode,
  input  logic [DATA_WIDTH-1:0]               s_d_data,
  input  logic [TAG_W-1:0]                    s_d_source,
  output logic [MASTERS-1:0]                  m_d_valid,
  input  logic [MASTERS-1:0]                  m_d_ready,
  output logic [2:0]                          m_d_opcode,
  output logic [DATA_WIDTH-1:0]               m_d_data,
  output logic [SRC_WIDTH-1:0]                m_d_source,
  output logic                                d_err
`ifdef TL_ARB_PERF_EN
  ,
  output logic [MASTERS-1:0][31:0]            perf_grant
`endif
);

  localparam int CNT_W = clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0]      count_r [MASTERS];
  logic [MASTERS-1:0]    eligible_s;
  logic [MASTERS-1:0]    grant_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic                  any_s;
  logic                  can_load_s;
  logic                  load_s;
  logic [MASTERS-1:0]    cnt_inc_s;
  logic [MASTERS-1:0]    cnt_dec_s;

  logic                  out_valid_r;
  logic [2:0]            out_opcode_r;
  logic [ADDR_WIDTH-1:0] out_address_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [TAG_W-1:0]      out_source_r;

  logic [IDX_W-1:0]      d_idx_s;
  logic                  d_cnt_nz_s;
  logic                  d_mready_s;
  logic                  d_ok_s;

  // A master may compete only while it has room for another outstanding request
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < MASTERS; i++) begin
      eligible_s[i] = m_a_valid[i] && (count_r[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(.WIDTH(MASTERS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible_s),
    .advance   (load_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  assign can_load_s = !out_valid_r || s_a_ready;
  assign load_s     = rst && can_load_s && any_s;
  assign m_a_ready  = (rst && can_load_s) ? grant_s : '0;
  assign cnt_inc_s  = m_a_valid & m_a_ready;

  // Single A output stage; payload only changes when the stage is free or draining
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r   <= 1'b0;
      out_opcode_r  <= 3'd0;
      out_address_r <= '0;
      out_data_r    <= '0;
      out_source_r  <= '0;
    end else if (load_s) begin
      out_valid_r   <= 1'b1;
      out_opcode_r  <= m_a_opcode[grant_idx_s];
      out_address_r <= m_a_address[grant_idx_s];
      out_data_r    <= m_a_data[grant_idx_s];
      out_source_r  <= {grant_idx_s, m_a_source[grant_idx_s]};
    end else if (s_a_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

  assign s_a_valid   = out_valid_r;
  assign s_a_opcode  = out_opcode_r;
  assign s_a_address = out_address_r;
  assign s_a_data    = out_data_r;
  assign s_a_source  = out_source_r;

  assign d_idx_s = s_d_source[TAG_W-1:SRC_WIDTH];

  // D is routable only to an existing master with a request outstanding
  always_comb begin
    d_cnt_nz_s = 1'b0;
    d_mready_s = 1'b0;
    m_d_valid  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      d_cnt_nz_s = d_cnt_nz_s | ((d_idx_s == IDX_W'(i)) && (count_r[i] != '0));
      d_mready_s = d_mready_s | ((d_idx_s == IDX_W'(i)) && m_d_ready[i]);
    end
    d_ok_s = d_cnt_nz_s;
    for (int i = 0; i < MASTERS; i++) begin
      m_d_valid[i] = rst && s_d_valid && d_ok_s && (d_idx_s == IDX_W'(i));
    end
  end

  assign s_d_ready  = d_ok_s ? d_mready_s : 1'b1;
  assign m_d_opcode = s_d_opcode;
  assign m_d_data   = s_d_data;
  assign m_d_source = s_d_source[SRC_WIDTH-1:0];
  assign cnt_dec_s  = m_d_valid & m_d_ready;

  // Outstanding counters; simultaneous accept and response cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MASTERS; i++) begin
        count_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        case ({cnt_inc_s[i], cnt_dec_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Sticky flag for a dropped, unroutable response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_err <= 1'b0;
    end else if (s_d_valid && !d_ok_s) begin
      d_err <= 1'b1;
    end
  end

`ifdef TL_ARB_PERF_EN
  // Accepted-transfer counters per master, saturating at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (cnt_inc_s[i] && (perf_grant[i] != 32'hFFFF_FFFF)) begin
          perf_grant[i] <= perf_grant[i] + 32'd1;
        end
      end
    end
  end
`else
  // Without the macro no grant counters exist.
`endif

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of grants, outstanding counts and D routing.
module tb_tl_ul_arbiter;

  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MO = 4;
  localparam int TW = SW + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [M-1:0]         m_a_valid;
  logic [M-1:0]         m_a_ready;
  logic [M-1:0][2:0]    m_a_opcode;
  logic [M-1:0][AW-1:0] m_a_address;
  logic [M-1:0][DW-1:0] m_a_data;
  logic [M-1:0][SW-1:0] m_a_source;
  logic                 s_a_valid;
  logic                 s_a_ready;
  logic [2:0]           s_a_opcode;
  logic [AW-1:0]        s_a_address;
  logic [DW-1:0]        s_a_data;
  logic [TW-1:0]        s_a_source;
  logic                 s_d_valid;
  logic                 s_d_ready;
  logic [2:0]           s_d_opcode;
  logic [DW-1:0]        s_d_data;
  logic [TW-1:0]        s_d_source;
  logic [M-1:0]         m_d_valid;
  logic [M-1:0]         m_d_ready;
  logic [2:0]           m_d_opcode;
  logic [DW-1:0]        m_d_data;
  logic [SW-1:0]        m_d_source;
  logic                 d_err;

  tl_ul_arbiter #(
    .MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
    .m_a_address(m_a_address), .m_a_data(m_a_data), .m_a_source(m_a_source),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_source(s_a_source),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_data(s_d_data), .s_d_source(s_d_source),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
    .m_d_data(m_d_data), .m_d_source(m_d_source), .d_err(d_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          cnt [M];
  int          ptr;
  bit          ov;
  bit          derr;
  logic [2:0]  e_op;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [TW-1:0] e_src;
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) cnt[i] = 0;
    ptr  = 0;
    ov   = 1'b0;
    derr = 1'b0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < M; i++) begin
      m_a_opcode[i]  = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd0;
      m_a_address[i] = AW'($urandom);
      m_a_data[i]    = DW'($urandom);
      m_a_source[i]  = SW'($urandom);
    end
    s_d_opcode = 3'($urandom_range(0, 1));
    s_d_data   = DW'($urandom);
  endtask

  // One clock: check outputs against the model, then advance the model
  task automatic cycle();
    int   win;
    int   didx;
    bit   can;
    bit   dok;
    logic [M-1:0] exp_ready;
    logic [M-1:0] exp_dv;
    bit   exp_sdr;
    #1;
    chk("s_a_valid", 64'(s_a_valid), 64'(ov));
    if (ov) begin
      chk("s_a_opcode",  64'(s_a_opcode),  64'(e_op));
      chk("s_a_address", 64'(s_a_address), 64'(e_addr));
      chk("s_a_data",    64'(s_a_data),    64'(e_data));
      chk("s_a_source",  64'(s_a_source),  64'(e_src));
    end
    chk("d_err", 64'(d_err), 64'(derr));
    can = !ov || s_a_ready;
    win = -1;
    for (int k = 0; k < M; k++) begin
      int c;
      c = (ptr + k) % M;
      if (win < 0 && m_a_valid[c] && cnt[c] < MO) win = c;
    end
    exp_ready = (can && win >= 0) ? M'(1 << win) : '0;
    chk("m_a_ready", 64'(m_a_ready), 64'(exp_ready));
    didx    = int'(s_d_source) / (1 << SW);
    dok     = (didx < M) && (cnt[didx] > 0);
    exp_dv  = (s_d_valid && dok) ? M'(1 << didx) : '0;
    exp_sdr = dok ? m_d_ready[didx] : 1'b1;
    chk("m_d_valid",  64'(m_d_valid),  64'(exp_dv));
    chk("s_d_ready",  64'(s_d_ready),  64'(exp_sdr));
    chk("m_d_source", 64'(m_d_source), 64'(int'(s_d_source) % (1 << SW)));
    if (ov && s_a_ready) ov = 1'b0;
    if (can && win >= 0) begin
      ov     = 1'b1;
      e_op   = m_a_opcode[win];
      e_addr = m_a_address[win];
      e_data = m_a_data[win];
      e_src  = {2'(win), m_a_source[win]};
      ptr    = (win + 1) % M;
      cnt[win]++;
    end
    if (s_d_valid && dok && m_d_ready[didx]) cnt[didx]--;
    if (s_d_valid && !dok) derr = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
    chk("rst_m_d_valid", 64'(m_d_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_a_valid  = '0;
    s_a_ready  = 1'b1;
    s_d_valid  = 1'b0;
    s_d_source = '0;
    m_d_ready  = '1;
    rand_payload();
    model_reset();

    // Reset held with activity on every input
    m_a_valid  = 3'b111;
    s_d_valid  = 1'b1;
    s_d_source = 6'h13;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("reset_m_a_ready", 64'(m_a_ready), 64'd0);
    chk("reset_m_d_valid", 64'(m_d_valid), 64'd0);
    chk("reset_d_err",     64'(d_err),     64'd0);
    @(negedge clk);
    rst       = 1'b1;
    m_a_valid = '0;
    s_d_valid = 1'b0;
    cycle();

    // Two continuously valid masters alternate
    m_a_valid = 3'b011;
    for (int k = 0; k < 6; k++) begin
      rand_payload();
      cycle();
      chk("alt_src_msb", 64'(s_a_source[TW-1:SW]), 64'(k % 2));
    end
    m_a_valid = '0;
    cycle();

    // Outstanding limit on master 0 while master 1 keeps being granted
    do_reset();
    m_a_valid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      m_a_opcode[0] = 3'd4;
      if (k == 4) begin
        #1;
        chk("fifth_get_blocked", 64'(m_a_ready[0]), 64'd0);
      end
      cycle();
    end
    m_a_valid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      rand_payload();
      cycle();
      chk("m1_granted", 64'(s_a_source[TW-1:SW]), 64'd1);
    end
    m_a_valid = '0;
    cycle();

    // D routed to master 1 with two outstanding
    do_reset();
    m_a_valid = 3'b010;
    repeat (2) begin rand_payload(); cycle(); end
    m_a_valid  = '0;
    s_d_valid  = 1'b1;
    s_d_source = 6'h13;
    #1;
    chk("d_route_valid",  64'(m_d_valid),  64'h2);
    chk("d_route_source", 64'(m_d_source), 64'h3);
    cycle();
    cycle();
    cycle();
    s_d_valid = 1'b0;
    cycle();
    chk("d_err_after_drain", 64'(d_err), 64'd1);

    // Unexpected D for master 0, then for a nonexistent master
    do_reset();
    s_d_valid  = 1'b1;
    s_d_source = 6'h05;
    m_d_ready  = '0;
    #1;
    chk("err_s_d_ready", 64'(s_d_ready), 64'd1);
    chk("err_m_d_valid", 64'(m_d_valid), 64'd0);
    cycle();
    s_d_valid = 1'b0;
    m_d_ready = '1;
    repeat (2) cycle();
    chk("d_err_sticky", 64'(d_err), 64'd1);
    do_reset();
    s_d_valid  = 1'b1;
    s_d_source = 6'h31;
    cycle();
    s_d_valid = 1'b0;
    m_a_valid = 3'b001;
    repeat (4) begin rand_payload(); cycle(); end
    m_a_valid = '0;
    cycle();
    chk("d_err_bad_index", 64'(d_err), 64'd1);

    // Back-pressure: held request stays stable for three cycles
    do_reset();
    s_a_ready = 1'b0;
    m_a_valid = 3'b100;
    rand_payload();
    hold_data = m_a_data[2];
    cycle();
    m_a_valid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      rand_payload();
      cycle();
      chk("stall_data", 64'(s_a_data), 64'(hold_data));
    end
    s_a_ready = 1'b1;
    m_a_valid = '0;
    cycle();
    chk("stall_released", 64'(s_a_valid), 64'd0);

    // Reset while the output stage holds a request
    s_a_ready = 1'b0;
    m_a_valid = 3'b001;
    rand_payload();
    cycle();
    chk("pre_reset_valid", 64'(s_a_valid), 64'd1);
    m_a_valid = '0;
    do_reset();
    s_a_ready = 1'b1;
    cycle();
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_payload();
      m_a_valid  = M'($urandom);
      s_a_ready  = ($urandom_range(0, 3) != 0);
      s_d_valid  = ($urandom_range(0, 1) == 1);
      s_d_source = {2'($urandom_range(0, (n < 200) ? 2 : 3)), SW'($urandom)};
      m_d_ready  = M'($urandom);
      if (n == 250) do_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
